// File: rtl/mdu_alu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the MIPS core.
// It owns no adder. Every arithmetic step is issued to the shared 32-bit ALU
// through a request/grant handshake, and each step completes only when the
// ALU is granted. The pipeline has priority, so a step can stall for any
// number of cycles. HI/LO hold the result for MFHI/MFLO.
//
// Flow: IDLE -> NEGA -> NEGB -> ITER(x32) -> FIXL -> FIXH -> DONE -> IDLE
//   NEGA/NEGB : take the operand magnitudes (lo <= |A|, bmag <= |B|)
//   ITER      : shift-add multiply or restoring divide on {hi,lo}
//   FIXL/FIXH : restore the signs of the result words and patch divide-by-zero
module mdu_alu_sequencer #(
  parameter int unsigned XLEN    = 32,
  parameter logic [5:0]  FUN_ADD = 6'b000000,
  parameter logic [5:0]  FUN_SUB = 6'b000001
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [5:0]      alu_fun,
  output logic            alu_sign,
  input  logic [XLEN-1:0] alu_s
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NEGA = 3'd1;
  localparam logic [2:0] S_NEGB = 3'd2;
  localparam logic [2:0] S_ITER = 3'd3;
  localparam logic [2:0] S_FIXL = 3'd4;
  localparam logic [2:0] S_FIXH = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  // State and datapath registers
  logic [2:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;        // original op_a (needed for divide-by-zero)
  logic [XLEN-1:0] b_q, b_d;        // original op_b
  logic [XLEN-1:0] bmag_q, bmag_d;  // |op_b|
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            lo_zero_q, lo_zero_d;
  logic            div_zero_q, div_zero_d;
  logic            busy_q;
  logic            done_q;

  // Decoded operation attributes and per-step helpers
  logic            is_signed_s;
  logic            is_div_s;
  logic            sign_a_s;
  logic            sign_b_s;
  logic            neg_res_s;
  logic            neg_rem_s;
  logic [XLEN-1:0] rem_s;       // partial remainder shifted left by one
  logic            mul_carry_s;
  logic [XLEN-1:0] mul_sum_s;
  logic            div_ge_s;

  // ALU drive
  logic            alu_req_s;
  logic [XLEN-1:0] alu_a_s;
  logic [XLEN-1:0] alu_b_s;
  logic [5:0]      alu_fun_s;

  // The operation signs come from the latched operands, so they stay stable for the whole operation.
  assign is_signed_s = op_q[0];
  assign is_div_s    = op_q[1];
  assign sign_a_s    = is_signed_s & a_q[XLEN-1];
  assign sign_b_s    = is_signed_s & b_q[XLEN-1];
  assign neg_res_s   = sign_a_s ^ sign_b_s;
  assign neg_rem_s   = sign_a_s;

  // The multiply carry is valid only when the step adds, that is, when the multiplier LSB is 1.
  assign mul_carry_s = lo_q[0] & (alu_s < hi_q);
  assign mul_sum_s   = lo_q[0] ? alu_s : hi_q;
  assign rem_s       = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign div_ge_s    = hi_q[XLEN-1] | (rem_s >= bmag_q);

  // Drive the ALU operands and function for the step the current state wants to complete.
  always_comb begin
    alu_req_s = 1'b0;
    alu_a_s   = ZERO;
    alu_b_s   = ZERO;
    alu_fun_s = FUN_ADD;
    case (state_q)
      S_NEGA: begin
        alu_req_s = 1'b1;
        if (sign_a_s) begin
          alu_a_s   = ZERO;
          alu_b_s   = a_q;
          alu_fun_s = FUN_SUB;
        end else begin
          alu_a_s   = a_q;
          alu_b_s   = ZERO;
          alu_fun_s = FUN_ADD;
        end
      end
      S_NEGB: begin
        alu_req_s = 1'b1;
        if (sign_b_s) begin
          alu_a_s   = ZERO;
          alu_b_s   = b_q;
          alu_fun_s = FUN_SUB;
        end else begin
          alu_a_s   = b_q;
          alu_b_s   = ZERO;
          alu_fun_s = FUN_ADD;
        end
      end
      S_ITER: begin
        alu_req_s = 1'b1;
        if (is_div_s) begin
          alu_a_s   = rem_s;
          alu_b_s   = bmag_q;
          alu_fun_s = FUN_SUB;
        end else begin
          alu_a_s   = hi_q;
          alu_b_s   = bmag_q;
          alu_fun_s = FUN_ADD;
        end
      end
      S_FIXL: begin
        alu_req_s = 1'b1;
        if (neg_res_s) begin
          alu_a_s   = ZERO;
          alu_b_s   = lo_q;
          alu_fun_s = FUN_SUB;
        end else begin
          alu_a_s   = lo_q;
          alu_b_s   = ZERO;
          alu_fun_s = FUN_ADD;
        end
      end
      S_FIXH: begin
        alu_req_s = 1'b1;
        if (is_div_s) begin
          if (neg_rem_s) begin
            alu_a_s   = ZERO;
            alu_b_s   = hi_q;
            alu_fun_s = FUN_SUB;
          end else begin
            alu_a_s   = hi_q;
            alu_b_s   = ZERO;
            alu_fun_s = FUN_ADD;
          end
        end else begin
          // Two's-complement negation of a 64-bit value: the low-word borrow propagates as ~hi + (lo==0).
          if (neg_res_s) begin
            alu_a_s   = ~hi_q;
            alu_b_s   = {{(XLEN-1){1'b0}}, lo_zero_q};
            alu_fun_s = FUN_ADD;
          end else begin
            alu_a_s   = hi_q;
            alu_b_s   = ZERO;
            alu_fun_s = FUN_ADD;
          end
        end
      end
      default: begin
        alu_req_s = 1'b0;
        alu_a_s   = ZERO;
        alu_b_s   = ZERO;
        alu_fun_s = FUN_ADD;
      end
    endcase
  end

  // Next-state and datapath updates; a requesting state changes nothing until it is granted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    bmag_d     = bmag_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    lo_zero_d  = lo_zero_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          state_d    = S_NEGA;
          op_d       = op;
          a_d        = op_a;
          b_d        = op_b;
          cnt_d      = 5'd31;
          div_zero_d = 1'b0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_NEGA: begin
        if (alu_gnt) begin
          lo_d    = alu_s;
          hi_d    = ZERO;
          state_d = S_NEGB;
        end else begin
          state_d = S_NEGA;
        end
      end
      S_NEGB: begin
        if (alu_gnt) begin
          bmag_d  = alu_s;
          state_d = S_ITER;
        end else begin
          state_d = S_NEGB;
        end
      end
      S_ITER: begin
        if (alu_gnt) begin
          if (is_div_s) begin
            hi_d = div_ge_s ? alu_s : rem_s;
            lo_d = {lo_q[XLEN-2:0], div_ge_s};
          end else begin
            hi_d = {mul_carry_s, mul_sum_s[XLEN-1:1]};
            lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == 5'd0) begin
            state_d = S_FIXL;
          end else begin
            cnt_d   = cnt_q - 5'd1;
          end
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIXL: begin
        if (alu_gnt) begin
          lo_zero_d = (lo_q == ZERO);
          lo_d      = alu_s;
          state_d   = S_FIXH;
        end else begin
          state_d   = S_FIXL;
        end
      end
      S_FIXH: begin
        if (alu_gnt) begin
          state_d = S_DONE;
          // A divide by zero still runs the full sequence; its result is replaced here.
          if (is_div_s && (b_q == ZERO)) begin
            hi_d       = a_q;
            lo_d       = ONES;
            div_zero_d = 1'b1;
          end else begin
            hi_d       = alu_s;
          end
        end else begin
          state_d = S_FIXH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequential state; busy/done are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 2'b00;
      a_q        <= ZERO;
      b_q        <= ZERO;
      bmag_q     <= ZERO;
      hi_q       <= ZERO;
      lo_q       <= ZERO;
      lo_zero_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      bmag_q     <= bmag_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      lo_zero_q  <= lo_zero_d;
      div_zero_q <= div_zero_d;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign alu_req  = alu_req_s;
  assign alu_a    = alu_a_s;
  assign alu_b    = alu_b_s;
  assign alu_fun  = alu_fun_s;
  assign alu_sign = 1'b0;

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Bench for mdu_alu_sequencer: directed corner cases plus randomized
// operations and grant patterns, checked against a plain-arithmetic model.
module tb_mdu_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic        alu_req, alu_gnt;
  logic [31:0] alu_a, alu_b, alu_s;
  logic [5:0]  alu_fun;
  logic        alu_sign;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Shared ALU: adder group, bit0 selects subtract
  assign alu_s = alu_fun[0] ? (alu_a - alu_b) : (alu_a + alu_b);

  mdu_alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo),
    .alu_req  (alu_req),
    .alu_gnt  (alu_gnt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_fun  (alu_fun),
    .alu_sign (alu_sign),
    .alu_s    (alu_s)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS MULT/MULTU/DIV/DIVU results from ordinary 64-bit arithmetic
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    rdz = 1'b0;
    if (o == 2'b00) begin
      p   = {32'd0, a} * {32'd0, b};
      rhi = p[63:32];
      rlo = p[31:0];
    end else if (o == 2'b01) begin
      p   = sa * sb;
      rhi = p[63:32];
      rlo = p[31:0];
    end else if (b == 32'd0) begin
      rhi = a;
      rlo = 32'hFFFF_FFFF;
      rdz = 1'b1;
    end else if (o == 2'b10) begin
      rlo = a / b;
      rhi = a % b;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      rlo = q[31:0];
      rhi = r[31:0];
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One operation. mode 0: grant always; 1: grant 1010.. from the accept cycle; 2: random grant.
  // noise: randomly pulse start with junk operands while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input bit noise);
    logic [31:0] ehi, elo;
    logic        edz;
    logic        g;
    logic        prev_stall;
    logic [31:0] pa, pb;
    logic [5:0]  pf;
    int          grants;
    int          c;
    ref_model(o, a, b, ehi, elo, edz);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b; alu_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    grants = 0; c = 1; prev_stall = 1'b0; pa = '0; pb = '0; pf = '0;
    // 36 granted steps are needed; done follows the cycle of the last grant
    while (grants < 36 && c < 400) begin
      check_val("busy_run", 64'(busy), 64'd1);
      check_val("req_run", 64'(alu_req), 64'd1);
      check_val("done_early", 64'(done), 64'd0);
      check_val("alu_sign", 64'(alu_sign), 64'd0);
      if (prev_stall) begin
        check_val("stall_alu_a", 64'(alu_a), 64'(pa));
        check_val("stall_alu_b", 64'(alu_b), 64'(pb));
        check_val("stall_alu_fun", 64'(alu_fun), 64'(pf));
      end
      if (mode == 0)      g = 1'b1;
      else if (mode == 1) g = (c % 2 == 0);
      else                g = 1'($urandom_range(0, 1));
      alu_gnt    = g;
      prev_stall = !g;
      pa = alu_a; pb = alu_b; pf = alu_fun;
      if (g) grants++;
      if (noise && ($urandom_range(0, 7) == 0)) begin
        start = 1'b1; op = 2'($urandom); op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    alu_gnt = 1'($urandom_range(0, 1));
    check_val("no_timeout", 64'(c < 400), 64'd1);
    if (mode == 0) check_val("latency_gnt1", 64'(c), 64'd37);
    if (mode == 1) check_val("latency_gnt1010", 64'(c), 64'd73);
    check_val("done_pulse", 64'(done), 64'd1);
    check_val("busy_at_done", 64'(busy), 64'd0);
    check_val("req_at_done", 64'(alu_req), 64'd0);
    check_val("hi", 64'(hi), 64'(ehi));
    check_val("lo", 64'(lo), 64'(elo));
    check_val("div_zero", 64'(div_zero), 64'(edz));
    @(negedge clk);
    check_val("done_one_cycle", 64'(done), 64'd0);
    check_val("hi_hold", 64'(hi), 64'(ehi));
    check_val("lo_hold", 64'(lo), 64'(elo));
    check_val("div_zero_hold", 64'(div_zero), 64'(edz));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0; alu_gnt = 1'b0;
    #12;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_div_zero", 64'(div_zero), 64'd0);
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    check_val("rst_req", 64'(alu_req), 64'd0);
    check_val("rst_alu_a", 64'(alu_a), 64'd0);
    check_val("rst_alu_b", 64'(alu_b), 64'd0);
    check_val("rst_alu_fun", 64'(alu_fun), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(2'b10, 32'd100, 32'd7, 0, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("div_zero_sticky", 64'(div_zero), 64'd1);
    run_op(2'b00, 32'd3, 32'd4, 0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b00, 32'd12345, 32'd6789, 1, 1'b0);
    run_op(2'b11, 32'd1000, 32'hFFFF_FFF3, 0, 1'b1);

    // Reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; op = 2'b11; op_a = 32'hFFFF_FF9C; op_b = 32'd7; alu_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_val("mid_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_hi", 64'(hi), 64'd0);
    check_val("abort_lo", 64'(lo), 64'd0);
    check_val("abort_req", 64'(alu_req), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b11, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);

    // Randomized operations and grant patterns
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick_operand(), pick_operand(), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
